// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the fetch/data memory arbiter.
// Holds the arbiter state encoding and the port identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arbState_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  // Wide enough for MEM_LAT-1 over the legal range 1..15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/arb_lat_cnt.sv
// arb_lat_cnt: memory access latency down-counter.
// Loads a start value, counts down to zero and flags zero.
module arb_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load wins over decrement; never wrap below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports.
// Define ARB_RR_EN for round-robin ties; default build gives data priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_INIT =
    CNT_W'(MEM_LAT - 1);

  arbState_e state;
  arbState_e stateNext;

  logic              grantQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic              wrQ;
  logic [DATA_W-1:0] ifRdataQ;
  logic [DATA_W-1:0] dmRdataQ;

  logic anyReq;
  logic doGrant;
  logic pickDm;
  logic cntLoad;
  logic cntDec;
  logic cntZero;
  logic lastBusy;

  assign anyReq   = if_req | dm_req;
  assign lastBusy = (state == BUSY) & cntZero;

`ifdef ARB_RR_EN
  logic lastGrant;

  // Remember who was served last so a tie alternates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGrant <= PORT_IF;
    end else if (doGrant) begin
      lastGrant <= pickDm ? PORT_DM : PORT_IF;
    end
  end

  // Tie goes to the port that did not win last time.
  always_comb begin
    pickDm = dm_req & (~if_req | (lastGrant == PORT_IF));
  end
`else
  // Data port wins every tie.
  always_comb begin
    pickDm = dm_req;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and counter controls.
  always_comb begin
    stateNext = state;
    doGrant   = 1'b0;
    cntLoad   = 1'b0;
    cntDec    = 1'b0;
    unique case (state)
      IDLE: begin
        if (anyReq) begin
          doGrant   = 1'b1;
          cntLoad   = 1'b1;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (cntZero) begin
          stateNext = DONE;
        end else begin
          cntDec = 1'b1;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Latch the winning command; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grantQ <= PORT_IF;
      addrQ  <= '0;
      wdataQ <= '0;
      wrQ    <= 1'b0;
    end else if (doGrant) begin
      unique case (1'b1)
        pickDm: begin
          grantQ <= PORT_DM;
          addrQ  <= dm_addr;
          wdataQ <= dm_wdata;
          wrQ    <= dm_wr;
        end
        default: begin
          grantQ <= PORT_IF;
          addrQ  <= if_addr;
          wrQ    <= 1'b0;
        end
      endcase
    end
  end

  // Capture read data on the last busy cycle; writes leave rdata alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifRdataQ <= '0;
      dmRdataQ <= '0;
    end else if (lastBusy && !wrQ) begin
      if (grantQ == PORT_DM) begin
        dmRdataQ <= mem_rdata;
      end else begin
        ifRdataQ <= mem_rdata;
      end
    end
  end

  arb_lat_cnt #(
    .W(CNT_W)
  ) uLatCnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cntLoad),
    .loadVal(LAT_INIT),
    .dec    (cntDec),
    .zero   (cntZero)
  );

  assign mem_en    = (state == BUSY);
  assign mem_wr    = (state == BUSY) & wrQ;
  assign mem_addr  = addrQ;
  assign mem_wdata = wdataQ;

  assign if_done = (state == DONE) & (grantQ == PORT_IF);
  assign dm_done = (state == DONE) & (grantQ == PORT_DM);

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  assign if_rdata = ifRdataQ;
  assign dm_rdata = dmRdataQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench for mem_arbiter against a timeline model.
// Each grant schedules busy/done cycles arithmetically from the request cycle.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        if_req, if_done, if_stall;
  logic [15:0] if_addr, if_rdata;
  logic        dm_req, dm_wr, dm_done, dm_stall;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        bIfReq, bIfDone, bIfStall;
  logic [15:0] bIfAddr, bIfRdata;
  logic        bDmReq, bDmWr, bDmDone, bDmStall;
  logic [15:0] bDmAddr, bDmWdata, bDmRdata;
  logic        bMemEn, bMemWr;
  logic [15:0] bMemAddr, bMemWdata, bMemRdata;

  mem_arbiter #(.MEM_LAT(LAT), .ADDR_W(16), .DATA_W(16)) u0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(1), .ADDR_W(16), .DATA_W(16)) u1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(bIfReq), .if_addr(bIfAddr), .if_rdata(bIfRdata),
    .if_done(bIfDone), .if_stall(bIfStall),
    .dm_req(bDmReq), .dm_wr(bDmWr), .dm_addr(bDmAddr),
    .dm_wdata(bDmWdata), .dm_rdata(bDmRdata),
    .dm_done(bDmDone), .dm_stall(bDmStall),
    .mem_en(bMemEn), .mem_wr(bMemWr), .mem_addr(bMemAddr),
    .mem_wdata(bMemWdata), .mem_rdata(bMemRdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model of the single outstanding access.
  bit          active;
  int          busyStart, doneCyc;
  bit          gPort, gWr, lastG;
  logic [15:0] gAddr, gWdata;

  // Requester state per port (0 = fetch, 1 = data).
  bit          pend [2];
  logic [15:0] pAddr [2];
  logic [15:0] pWdata;
  bit          pWr;
  int          newProb, dropProb;

  logic [15:0] memArr [16];
  logic [15:0] expIfRd, expDmRd;

  task automatic checkVal(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic issue(input int p);
    pend[p]  = 1'b1;
    pAddr[p] = 16'($urandom);
    if (p == 1) begin
      pWdata = 16'($urandom);
      pWr    = 1'($urandom);
    end
  endtask

  task automatic modelReset();
    active  = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    lastG   = 1'b0;
    expIfRd = '0;
    expDmRd = '0;
  endtask

  task automatic stepCycle();
    bit inBusy, pickDm, expEn, expIfDone, expDmDone;
    @(posedge clk);
    #1;
    cyc++;
    inBusy = active && cyc >= busyStart && cyc < doneCyc;
    if (inBusy && pend[gPort] && $urandom_range(99) < dropProb)
      pend[gPort] = 1'b0;
    if_req = pend[0];
    dm_req = pend[1];
    if (inBusy && gPort == 1'b0) if_addr = 16'($urandom);
    else if_addr = pAddr[0];
    if (inBusy && gPort == 1'b1) begin
      dm_addr  = 16'($urandom);
      dm_wdata = 16'($urandom);
      dm_wr    = 1'($urandom);
    end else begin
      dm_addr  = pAddr[1];
      dm_wdata = pWdata;
      dm_wr    = pWr;
    end
    if (!active && (pend[0] || pend[1])) begin
`ifdef ARB_RR_EN
      pickDm = pend[1] && (!pend[0] || lastG == 1'b0);
`else
      pickDm = pend[1];
`endif
      gPort     = pickDm;
      gAddr     = pAddr[pickDm];
      gWdata    = pWdata;
      gWr       = pickDm && pWr;
      lastG     = pickDm;
      busyStart = cyc + 1;
      doneCyc   = cyc + LAT + 1;
      active    = 1'b1;
    end
    if (active && cyc == doneCyc - 1 && !gWr)
      mem_rdata = memArr[gAddr[3:0]];
    else
      mem_rdata = 16'($urandom);
    @(negedge clk);
    expEn     = active && cyc >= busyStart && cyc < doneCyc;
    expIfDone = active && cyc == doneCyc && !gPort;
    expDmDone = active && cyc == doneCyc && gPort;
    if (active && cyc == doneCyc && !gWr) begin
      if (gPort) expDmRd = memArr[gAddr[3:0]];
      else expIfRd = memArr[gAddr[3:0]];
    end
    checkVal("memEn", mem_en, expEn);
    checkVal("memWr", mem_wr, expEn && gWr);
    checkVal("ifDone", if_done, expIfDone);
    checkVal("dmDone", dm_done, expDmDone);
    checkVal("ifStall", if_stall, if_req && !expIfDone);
    checkVal("dmStall", dm_stall, dm_req && !expDmDone);
    checkVal("ifRdata", if_rdata, expIfRd);
    checkVal("dmRdata", dm_rdata, expDmRd);
    if (expEn) checkVal("memAddr", mem_addr, gAddr);
    if (expEn && gWr) checkVal("memWdata", mem_wdata, gWdata);
    if (active && cyc == doneCyc) begin
      if (gWr) memArr[gAddr[3:0]] = gWdata;
      pend[gPort] = 1'b0;
      active = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      if (!pend[p] && !(active && gPort == p[0]) &&
          $urandom_range(99) < newProb)
        issue(p);
    end
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) stepCycle();
  endtask

  int doneAt, enCnt, doneCnt;

  initial begin
    if_req = 0; if_addr = 0; dm_req = 0; dm_wr = 0;
    dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    bIfReq = 0; bIfAddr = 0; bDmReq = 0; bDmWr = 0;
    bDmAddr = 0; bDmWdata = 0; bMemRdata = 0;
    pAddr[0] = 0; pAddr[1] = 0; pWdata = 0; pWr = 0;
    for (int i = 0; i < 16; i++) memArr[i] = 16'($urandom);
    modelReset();
    newProb = 0;
    dropProb = 0;

    #12;
    checkVal("rstMemEn", mem_en, 1'b0);
    checkVal("rstMemWr", mem_wr, 1'b0);
    checkVal("rstIfDone", if_done, 1'b0);
    checkVal("rstDmDone", dm_done, 1'b0);
    checkVal("rstIfRdata", if_rdata, 16'h0);
    checkVal("rstDmRdata", dm_rdata, 16'h0);
    checkVal("rstMemAddr", mem_addr, 16'h0);
    checkVal("rstMemWdata", mem_wdata, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch from 0x0010 returning 0xBEEF.
    memArr[0] = 16'hBEEF;
    pend[0] = 1'b1;
    pAddr[0] = 16'h0010;
    runCycles(8);

    // Store 0x1234 to 0x0200.
    pend[1] = 1'b1;
    pAddr[1] = 16'h0200;
    pWdata = 16'h1234;
    pWr = 1'b1;
    runCycles(8);

    // Both ports requesting continuously.
    pWr = 1'b0;
    pend[0] = 1'b1;
    pend[1] = 1'b1;
    newProb = 100;
    runCycles(40);
    newProb = 0;
    runCycles(16);

    // Random traffic with abandoned requests and busy-time input noise.
    newProb = 40;
    dropProb = 10;
    runCycles(600);
    newProb = 0;
    dropProb = 0;
    runCycles(16);

    // Reset during the second busy cycle of a fetch.
    pend[0] = 1'b1;
    pAddr[0] = 16'($urandom);
    for (int k = 0; k < 12; k++) begin
      if (active && cyc == busyStart + 1) break;
      stepCycle();
    end
    checkVal("preRstEn", mem_en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("midRstEn", mem_en, 1'b0);
    checkVal("midRstWr", mem_wr, 1'b0);
    checkVal("midRstIfDone", if_done, 1'b0);
    checkVal("midRstDmDone", dm_done, 1'b0);
    checkVal("midRstIfRd", if_rdata, 16'h0);
    checkVal("midRstDmRd", dm_rdata, 16'h0);
    checkVal("midRstAddr", mem_addr, 16'h0);
    modelReset();
    if_req = 0;
    dm_req = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    runCycles(6);

    // Fresh tie after reset: data must win first.
    pend[0] = 1'b1;
    pend[1] = 1'b1;
    pAddr[0] = 16'h0100;
    pAddr[1] = 16'h0101;
    runCycles(16);

    // MEM_LAT=1 instance: read of 0x0004.
    doneAt = -1;
    enCnt = 0;
    doneCnt = 0;
    @(posedge clk);
    #1;
    bIfReq = 1'b1;
    bIfAddr = 16'h0004;
    bMemRdata = 16'hA5C3;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bMemEn) enCnt++;
      if (bIfDone) begin
        doneCnt++;
        if (doneAt < 0) doneAt = k;
      end
      @(posedge clk);
      #1;
      if (doneAt >= 0) bIfReq = 1'b0;
    end
    checkVal("lat1DoneAt", 32'(doneAt), 32'd2);
    checkVal("lat1EnCnt", 32'(enCnt), 32'd1);
    checkVal("lat1DoneCnt", 32'(doneCnt), 32'd1);
    checkVal("lat1Rdata", bIfRdata, 16'hA5C3);
    checkVal("lat1Addr", bMemAddr, 16'h0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
